// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short press, long press and double click.
// Each class is emitted as a registered one-cycle tick, with a wrapping event count and last class.
module press_classifier #(
   parameter int unsigned LONG_CYCLES    = 50_000_000,
   parameter int unsigned DBL_GAP_CYCLES = 25_000_000,
   parameter int unsigned TMR_W          = $clog2((LONG_CYCLES > DBL_GAP_CYCLES) ?
                                                  LONG_CYCLES : DBL_GAP_CYCLES) + 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       db_level_i,
   input  logic       clr_i,
   output logic       short_tick_o,
   output logic       long_tick_o,
   output logic       double_tick_o,
   output logic       held_o,
   output logic [1:0] last_class_o,
   output logic [7:0] event_cnt_o
);

   typedef enum logic [2:0] {
      StIdle,
      StPress1,
      StWait2,
      StPress2,
      StLongHold
   } state_e;

   localparam logic [1:0]       ClsNone   = 2'b00;
   localparam logic [1:0]       ClsShort  = 2'b01;
   localparam logic [1:0]       ClsLong   = 2'b10;
   localparam logic [1:0]       ClsDouble = 2'b11;
   localparam logic [TMR_W-1:0] TmrMax    = '1;
   localparam logic [TMR_W-1:0] LongLast  = TMR_W'(LONG_CYCLES - 1);
   localparam logic [TMR_W-1:0] GapLast   = TMR_W'(DBL_GAP_CYCLES - 1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             level_q;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             double_q, double_d;
   logic [1:0]       class_q, class_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             rise;

   assign rise = db_level_i & ~level_q;

   always_comb begin
      state_d  = state_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      double_d = 1'b0;
      timer_d  = timer_q;
      class_d  = class_q;
      cnt_d    = cnt_q;

      // Release is tested before the timeout so it wins when both happen in one cycle.
      unique case (state_q)
         StIdle: begin
            if (rise) state_d = StPress1;
         end
         StPress1: begin
            if (!db_level_i) begin
               state_d = StWait2;
            end else if (timer_q == LongLast) begin
               state_d = StLongHold;
               long_d  = 1'b1;
            end
         end
         StWait2: begin
            if (db_level_i) begin
               state_d = StPress2;
            end else if (timer_q == GapLast) begin
               state_d = StIdle;
               short_d = 1'b1;
            end
         end
         StPress2: begin
            if (!db_level_i) begin
               state_d  = StIdle;
               double_d = 1'b1;
            end
         end
         StLongHold: begin
            if (!db_level_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q) begin
         timer_d = '0;
      end else if ((state_q == StPress1 || state_q == StWait2) && timer_q != TmrMax) begin
         timer_d = timer_q + TMR_W'(1);
      end

      if (short_d || long_d || double_d) begin
         cnt_d   = cnt_q + 8'd1;
         class_d = double_d ? ClsDouble : (long_d ? ClsLong : ClsShort);
      end

      // Clear discards any classification that would have fired this cycle.
      if (clr_i) begin
         state_d  = StIdle;
         timer_d  = '0;
         short_d  = 1'b0;
         long_d   = 1'b0;
         double_d = 1'b0;
         cnt_d    = 8'd0;
         class_d  = ClsNone;
      end
   end

   // level_q resets high so a button held through reset is not taken as a press.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         timer_q  <= '0;
         level_q  <= 1'b1;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         class_q  <= ClsNone;
         cnt_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         level_q  <= db_level_i;
         short_q  <= short_d;
         long_q   <= long_d;
         double_q <= double_d;
         class_q  <= class_d;
         cnt_q    <= cnt_d;
      end
   end

   assign short_tick_o  = short_q;
   assign long_tick_o   = long_q;
   assign double_tick_o = double_q;
   assign held_o        = (state_q == StLongHold);
   assign last_class_o  = class_q;
   assign event_cnt_o   = cnt_q;

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: level runs feed a run-length gesture model whose predicted
// events are queued and matched by a monitor against the DUT ticks.
module tb_press_classifier;

   localparam int unsigned L = 8;
   localparam int unsigned D = 5;

   typedef enum int {MIdle, MPress1, MGap, MPress2, MHold} mphase_e;
   typedef struct {
      logic [1:0]  cls;
      int unsigned at_edge;
      logic [7:0]  cnt;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       db = 1'b1;
   logic       clr = 1'b0;
   logic       short_tick, long_tick, double_tick, held;
   logic [1:0] last_class;
   logic [7:0] event_cnt;

   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   ev_t         exp_q[$];
   mphase_e     phase = MIdle;
   logic        prev_lvl = 1'b1;
   logic [7:0]  m_cnt = 8'd0;
   logic [1:0]  m_class = 2'b00;
   int unsigned held_from = 32'hFFFF_FFFF;
   int unsigned held_to = 32'hFFFF_FFFF;
   bit          mon_en = 1'b0;

   press_classifier #(
      .LONG_CYCLES   (L),
      .DBL_GAP_CYCLES(D)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .db_level_i   (db),
      .clr_i        (clr),
      .short_tick_o (short_tick),
      .long_tick_o  (long_tick),
      .double_tick_o(double_tick),
      .held_o       (held),
      .last_class_o (last_class),
      .event_cnt_o  (event_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic void emit(input logic [1:0] cls, input int unsigned e);
      ev_t ev;
      m_cnt      = m_cnt + 8'd1;
      m_class    = cls;
      ev.cls     = cls;
      ev.at_edge = e;
      ev.cnt     = m_cnt;
      exp_q.push_back(ev);
   endfunction

   // A run is len consecutive samples of one level, the first sampled at edge s.
   function automatic void model_run(input logic lvl, input int unsigned len,
                                     input int unsigned s);
      if (lvl) begin
         if (phase == MIdle && !prev_lvl) begin
            if (len >= L + 1) begin
               emit(2'b10, s + L);
               phase     = MHold;
               held_from = s + L;
               held_to   = 32'hFFFF_FFFF;
            end else begin
               phase = MPress1;
            end
         end else if (phase == MGap) begin
            phase = MPress2;
         end
      end else begin
         case (phase)
            MPress1: begin
               if (len >= D + 1) begin
                  emit(2'b01, s + D);
                  phase = MIdle;
               end else begin
                  phase = MGap;
               end
            end
            MPress2: begin
               emit(2'b11, s);
               phase = MIdle;
            end
            MHold: begin
               held_to = s;
               phase   = MIdle;
            end
            default: ;
         endcase
      end
      prev_lvl = lvl;
   endfunction

   task automatic run(input logic lvl, input int unsigned len);
      model_run(lvl, len, cyc + 1);
      for (int i = 0; i < int'(len); i++) begin
         db = lvl;
         @(negedge clk);
      end
   endtask

   function automatic int unsigned pick_high();
      case ($urandom_range(0, 5))
         0:       return 1;
         1:       return L - 1;
         2:       return L;
         3:       return L + 1;
         default: return $urandom_range(1, 2 * L);
      endcase
   endfunction

   function automatic int unsigned pick_low();
      case ($urandom_range(0, 5))
         0:       return 1;
         1:       return D - 1;
         2:       return D;
         3:       return D + 1;
         default: return $urandom_range(1, 2 * D);
      endcase
   endfunction

   always @(negedge clk) begin
      int   n;
      int   got;
      ev_t  ev;
      if (mon_en) begin
         chk("held", int'(held), int'(cyc >= held_from && cyc < held_to));
         while (exp_q.size() > 0 && exp_q[0].at_edge < cyc) begin
            ev = exp_q.pop_front();
            chk("missed_tick_edge", int'(cyc), int'(ev.at_edge));
         end
         n = int'(short_tick) + int'(long_tick) + int'(double_tick);
         if (n > 0) begin
            chk("one_tick", n, 1);
            got = double_tick ? 3 : (long_tick ? 2 : 1);
            if (exp_q.size() == 0) begin
               chk("unexpected_tick_class", got, 0);
            end else begin
               ev = exp_q.pop_front();
               chk("tick_class", got, int'(ev.cls));
               chk("tick_edge", int'(cyc), int'(ev.at_edge));
               chk("last_class", int'(last_class), int'(ev.cls));
               chk("event_cnt", int'(event_cnt), int'(ev.cnt));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      db    = 1'b1;
      clr   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_short", int'(short_tick), 0);
      chk("rst_long", int'(long_tick), 0);
      chk("rst_double", int'(double_tick), 0);
      chk("rst_held", int'(held), 0);
      chk("rst_class", int'(last_class), 0);
      chk("rst_cnt", int'(event_cnt), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Button held through reset is ignored, then a real short press.
      run(1'b1, 20);
      run(1'b0, 3);
      run(1'b1, 2);
      run(1'b0, D + 3);
      chk("short_cnt", int'(event_cnt), 1);
      chk("short_class", int'(last_class), 1);

      run(1'b1, 12);
      run(1'b0, D + 2);
      chk("long_class", int'(last_class), 2);

      run(1'b1, 2);
      run(1'b0, 2);
      run(1'b1, 2);
      run(1'b0, D + 2);
      chk("double_class", int'(last_class), 3);
      chk("double_cnt", int'(event_cnt), 3);

      // Gap of exactly D+1 low samples times out, next press starts fresh.
      run(1'b1, 2);
      run(1'b0, D + 1);
      run(1'b1, 2);
      run(1'b0, D + 2);

      // Clear in the middle of the first press.
      run(1'b1, 3);
      db  = 1'b1;
      clr = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      phase    = MIdle;
      m_cnt    = 8'd0;
      m_class  = 2'b00;
      prev_lvl = 1'b1;
      run(1'b1, 4);
      chk("clr_cnt", int'(event_cnt), 0);
      chk("clr_class", int'(last_class), 0);
      run(1'b0, 3);

      // Clear on the very edge a short press would be classified.
      run(1'b1, 2);
      run(1'b0, D + 1);
      run(1'b1, 2);
      db = 1'b0;
      repeat (D) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      phase    = MIdle;
      m_cnt    = 8'd0;
      m_class  = 2'b00;
      prev_lvl = 1'b0;
      run(1'b0, 4);
      chk("clr_pending_cnt", int'(event_cnt), 0);

      for (int k = 0; k < 256; k++) begin
         run(1'b1, 2);
         run(1'b0, D + 1);
      end
      chk("wrap_cnt", int'(event_cnt), 0);
      chk("wrap_class", int'(last_class), 1);

      for (int k = 0; k < 400; k++) begin
         run(1'b1, pick_high());
         run(1'b0, (k == 399) ? D + 2 : pick_low());
      end

      repeat (5) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("final_cnt", int'(event_cnt), int'(m_cnt));
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
